// File: rtl/spi_master_tx.sv
// SPI master transmit shift engine: pops FIFO words and shifts them MSB-first on tx_edge.
// Define SPI_TX_QUAD_EN to build the 4-bit-per-edge quad path (sdo_quad honoured).
module spi_master_tx #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  en,
    input  logic                  tx_edge,
    input  logic                  sdo_quad,
    input  logic [CNT_WIDTH-1:0]  counter_in,
    input  logic                  counter_in_upd,
    input  logic [DATA_WIDTH-1:0] txdata,
    input  logic                  txdata_valid,
    output logic                  txdata_ready,
    output logic                  clk_en_o,
    output logic                  tx_done,
    output logic                  sdo0,
    output logic                  sdo1,
    output logic                  sdo2,
    output logic                  sdo3
);

    localparam int WW = $clog2(DATA_WIDTH) + 1;
    localparam logic [WW-1:0] LAST_STD = WW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, TRANSMIT, STALL} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_WIDTH-1:0]  bit_cnt;
    logic [CNT_WIDTH-1:0]  target;
    logic [CNT_WIDTH-1:0]  target_nxt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic [WW-1:0]         word_cnt;
    logic [WW-1:0]         word_last;
    logic [DATA_WIDTH-1:0] data;
    logic [DATA_WIDTH-1:0] data_shl;
    logic                  last_edge;
    logic                  word_end;
    logic                  load;
    logic                  shift;
    logic                  done_set;
    logic                  cnt_inc;

`ifdef SPI_TX_QUAD_EN
    localparam logic [WW-1:0] LAST_QUAD = WW'(DATA_WIDTH / 4 - 1);

    logic                 quad;
    logic [CNT_WIDTH:0]   quad_round;

    assign quad_round = {1'b0, bit_cnt} + (CNT_WIDTH + 1)'(3);
    assign target_nxt = sdo_quad ? {1'b0, quad_round[CNT_WIDTH:2]} : bit_cnt;
    assign word_last  = quad ? LAST_QUAD : LAST_STD;
    assign data_shl   = quad ? {data[DATA_WIDTH-5:0], 4'b0000}
                             : {data[DATA_WIDTH-2:0], 1'b0};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            quad <= 1'b0;
        else if (load && state == IDLE)
            quad <= sdo_quad;
    end
`else
    logic unused_sdo_quad;

    assign unused_sdo_quad = sdo_quad;
    assign target_nxt      = bit_cnt;
    assign word_last       = LAST_STD;
    assign data_shl        = {data[DATA_WIDTH-2:0], 1'b0};
`endif

    assign last_edge = (edge_cnt == target - CNT_WIDTH'(1));
    assign word_end  = (word_cnt == word_last);
    assign cnt_inc   = (state == TRANSMIT) && en && tx_edge;

    always_comb begin
        state_nxt    = state;
        txdata_ready = 1'b0;
        clk_en_o     = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        done_set     = 1'b0;
        unique case (state)
            IDLE: begin
                if (en) begin
                    if (target_nxt == '0) begin
                        done_set = 1'b1;
                    end else if (txdata_valid) begin
                        txdata_ready = 1'b1;
                        load         = 1'b1;
                        state_nxt    = TRANSMIT;
                    end
                end
            end
            TRANSMIT: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (tx_edge) begin
                    if (last_edge) begin
                        done_set  = 1'b1;
                        state_nxt = IDLE;
                    end else if (word_end) begin
                        // data is left unshifted so a stall holds the last bit
                        if (txdata_valid) begin
                            txdata_ready = 1'b1;
                            load         = 1'b1;
                            clk_en_o     = 1'b1;
                        end else begin
                            state_nxt = STALL;
                        end
                    end else begin
                        shift    = 1'b1;
                        clk_en_o = 1'b1;
                    end
                end else begin
                    clk_en_o = 1'b1;
                end
            end
            STALL: begin
                if (!en) begin
                    state_nxt = IDLE;
                end else if (txdata_valid) begin
                    txdata_ready = 1'b1;
                    load         = 1'b1;
                    state_nxt    = TRANSMIT;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            target   <= '0;
            edge_cnt <= '0;
            word_cnt <= '0;
            data     <= '0;
            tx_done  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tx_done <= done_set;
            if (counter_in_upd)
                bit_cnt <= counter_in;
            if (load && state == IDLE) begin
                target   <= target_nxt;
                edge_cnt <= '0;
            end else if (cnt_inc) begin
                edge_cnt <= edge_cnt + CNT_WIDTH'(1);
            end
            if (load) begin
                data     <= txdata;
                word_cnt <= '0;
            end else if (shift) begin
                data     <= data_shl;
                word_cnt <= word_cnt + WW'(1);
            end
        end
    end

    always_comb begin
        sdo0 = 1'b0;
        sdo1 = 1'b0;
        sdo2 = 1'b0;
        sdo3 = 1'b0;
        if (state != IDLE) begin
`ifdef SPI_TX_QUAD_EN
            if (quad)
                {sdo3, sdo2, sdo1, sdo0} = data[DATA_WIDTH-1 -: 4];
            else
                sdo0 = data[DATA_WIDTH-1];
`else
            sdo0 = data[DATA_WIDTH-1];
`endif
        end
    end

endmodule

// File: doc/spi_master_tx.md
Name: spi_master_tx

Overview:
Transmit shift engine for the SPI master. It sits directly downstream of the SPI clock generator and consumes its `spi_fall` strobe as `tx_edge`. It pulls DATA_WIDTH-bit words from the TX FIFO over a valid/ready handshake and serialises them MSB-first onto `sdo0` (standard mode) or `sdo0..sdo3` (quad mode). It drives `clk_en_o` back to the clock generator's `en` input to start and stall SCK.

Parameters:
- DATA_WIDTH, 32, width of one FIFO word; must be a multiple of 4.
- CNT_WIDTH, 16, width of the transfer bit count.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- en  in  1  transfer enable from the controller FSM.
- tx_edge  in  1  single-cycle shift strobe (clock generator `spi_fall`).
- sdo_quad  in  1  1 = quad mode (4 bits per edge); 0 = standard mode (1 bit per edge).
- counter_in  in  CNT_WIDTH  total bits to transmit.
- counter_in_upd  in  1  loads `counter_in` into the target register.
- txdata  in  DATA_WIDTH  FIFO word.
- txdata_valid  in  1  FIFO word available.
- txdata_ready  out  1  word accepted this cycle.
- clk_en_o  out  1  SCK run request to the clock generator.
- tx_done  out  1  one-cycle pulse when the transfer completes.
- sdo0..sdo3  out  1 each  serial data outputs.

Behaviour:
Reset
- Async on `rstn` low. State = IDLE; counter, target register and data register cleared.
- All outputs 0: `sdo0..sdo3`, `txdata_ready`, `clk_en_o`, `tx_done`.
- Reset mid-transfer aborts immediately: no `tx_done`, no further FIFO pops.

Target register
- Bit count: `counter_in_upd` loads `counter_in` in any state, effective next cycle.
- Edge target, latched when the transfer starts:
  - standard mode: target edges = bit count.
  - quad mode: target edges = ceil(bit count / 4).
- Words per transfer = ceil(target / (DATA_WIDTH / bits-per-edge)).

States: IDLE, TRANSMIT, STALL.
- IDLE, `en` = 1 and target = 0: pulse `tx_done` for one cycle; no pop; stay IDLE.
- IDLE, `en` = 1, target > 0 and `txdata_valid` = 1:
  - assert `txdata_ready` combinationally for that cycle;
  - load `txdata`, clear the edge counter;
  - go to TRANSMIT with `clk_en_o` = 1.
- IDLE, `en` = 1 and `txdata_valid` = 0: wait; `clk_en_o` = 0.
- TRANSMIT, data outputs:
  - standard mode: `sdo0` = data[DATA_WIDTH-1]; `sdo1..sdo3` = 0.
  - quad mode: `sdo3..sdo0` = data[DATA_WIDTH-1 : DATA_WIDTH-4].
  - Outputs are valid from the cycle after the load.
- TRANSMIT, on each `tx_edge`: counter += 1; data shifts left by 1 (standard) or 4 (quad), zero fill.
- Word boundary (the edge that empties the word) with edges remaining:
  - `txdata_valid` = 1: pop in the same cycle (`txdata_ready` = 1), reload data, stay in TRANSMIT.
  - `txdata_valid` = 0: go to STALL; `clk_en_o` drops that cycle.
- Final edge (counter reaches target): `tx_done` = 1 for one cycle, `clk_en_o` = 0, return to IDLE. No pop.
- STALL:
  - `clk_en_o` = 0; `sdo` outputs hold.
  - On `txdata_valid`: pop, reload, back to TRANSMIT, `clk_en_o` = 1 next cycle.
- Abort: `en` low in TRANSMIT or STALL returns to IDLE next cycle. No `tx_done`; `clk_en_o` low that cycle.
- Simultaneity:
  - `tx_edge` in IDLE or STALL is ignored.
  - `counter_in_upd` during a transfer does not alter the latched target.
  - `sdo_quad` is sampled at transfer start only.

Optional Feature:
- Macro: SPI_TX_QUAD_EN.
- Defined: quad mode is implemented as described above.
- Undefined:
  - `sdo_quad` is ignored and treated as 0; `sdo1..sdo3` are tied to 0.
  - Target always equals the bit count; the 4-bit shift path is not synthesised.

Test Plan:
- Standard mode, 8-bit transfer: load count 8, word 0xA5000000 valid, `en` = 1, 8 `tx_edge` pulses → `sdo0` = 1,0,1,0,0,1,0,1; exactly one pop; `tx_done` one cycle after the 8th edge; `clk_en_o` = 0 after it.
- Multi-word with stall: count 64, first word 0xFFFFFFFF, second word 0x00000001 withheld 5 cycles after the 32nd edge → STALL with `clk_en_o` = 0 for 5 cycles; `sdo0` = 1 ×32, then 0 ×31, then 1; two pops total; one `tx_done`.
- Quad mode (SPI_TX_QUAD_EN): count 16, word 0x12340000 → 4 edges; `{sdo3..sdo0}` = 1,2,3,4; `tx_done` after the 4th edge. Count 6 → 2 edges.
- Zero-length: count 0, `en` = 1 → `tx_done` one cycle; `txdata_ready` never asserted; `clk_en_o` stays 0.
- Abort: count 32, drop `en` after 10 edges → IDLE next cycle; no `tx_done`; no further pops. `rstn` low mid-transfer → all outputs 0 asynchronously.
- Count update mid-transfer: `counter_in_upd` with 4 during a 32-bit transfer → still 32 edges; the next transfer uses 4.
